// File: rtl/minisrc_proc_pkg.sv
// Shared ISA definitions for the MiniSRC core: widths, reset PC, opcodes,
// FSM state encoding, ALU operation selector and instruction field slices.
package minisrc_proc_pkg;

    localparam int          DATA_W           = 32;
    localparam logic [31:0] START_PC_ADDRESS = 32'd0;
    localparam int          NUM_REGS         = 16;

    // Opcodes (instruction bits [31:27]); anything unlisted behaves as NOP
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Control FSM states, also exported on the debug port
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_EXEC   = 3'd1,
        ST_MEM    = 3'd2,
        ST_WB     = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // Operation selector for the combinational ALU
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NEG = 3'd4,
        ALU_NOT = 3'd5
    } alu_op_t;

    // Instruction field slices
    function automatic logic [4:0] ir_op(input logic [31:0] ir);
        return ir[31:27];
    endfunction

    function automatic logic [3:0] ir_ra(input logic [31:0] ir);
        return ir[26:23];
    endfunction

    function automatic logic [3:0] ir_rb(input logic [31:0] ir);
        return ir[22:19];
    endfunction

    function automatic logic [3:0] ir_rc(input logic [31:0] ir);
        return ir[18:15];
    endfunction

    // 19-bit constant field, sign-extended to the datapath width
    function automatic logic [DATA_W-1:0] ir_c_sext(input logic [31:0] ir);
        return {{(DATA_W-19){ir[18]}}, ir[18:0]};
    endfunction

endpackage

// File: rtl/minisrc_alu.sv
// Combinational ALU for MiniSRC: 32-bit wrap-around arithmetic and logic,
// no flags. Unary operations (NEG, NOT) use only operand a.
module minisrc_alu
    import minisrc_proc_pkg::*;
(
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    // Select the result for the requested operation
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_NEG: y = '0 - a;
            ALU_NOT: y = ~a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/minisrc_proc.sv
// MiniSRC multi-cycle core: FETCH -> EXEC -> (MEM) -> (WB) over a single
// shared memory port, 16-entry register file, HALT parks the core.
//
// Memory handshake: oMemRead/oMemWrite act as the request valid and are
// registered; the request (read/write, oMemAddr, oMemData) is raised on the
// edge that enters the access state and holds unchanged until an edge where
// iMemRdy=1, which completes the access (read data is sampled on that same
// edge). Read and write are never requested together.
module minisrc_proc #(
    parameter logic [31:0] START_PC_ADDRESS = minisrc_proc_pkg::START_PC_ADDRESS,
    parameter int          DATA_W           = minisrc_proc_pkg::DATA_W
) (
    input  logic                     iClk,
    input  logic                     iRst,
    output logic [DATA_W-1:0]        oMemAddr,
    output logic [DATA_W-1:0]        oMemData,
    input  logic [DATA_W-1:0]        iMemData,
    input  logic                     iMemRdy,
    output logic                     oMemRead,
    output logic                     oMemWrite,
    output minisrc_proc_pkg::state_t dbg_state
);

    import minisrc_proc_pkg::state_t;
    import minisrc_proc_pkg::alu_op_t;
    import minisrc_proc_pkg::ST_FETCH;
    import minisrc_proc_pkg::ST_EXEC;
    import minisrc_proc_pkg::ST_MEM;
    import minisrc_proc_pkg::ST_WB;
    import minisrc_proc_pkg::ST_HALTED;
    import minisrc_proc_pkg::ALU_ADD;
    import minisrc_proc_pkg::ALU_SUB;
    import minisrc_proc_pkg::ALU_AND;
    import minisrc_proc_pkg::ALU_OR;
    import minisrc_proc_pkg::ALU_NEG;
    import minisrc_proc_pkg::ALU_NOT;
    import minisrc_proc_pkg::OP_LD;
    import minisrc_proc_pkg::OP_ST;
    import minisrc_proc_pkg::OP_ADD;
    import minisrc_proc_pkg::OP_SUB;
    import minisrc_proc_pkg::OP_AND;
    import minisrc_proc_pkg::OP_OR;
    import minisrc_proc_pkg::OP_ADDI;
    import minisrc_proc_pkg::OP_NEG;
    import minisrc_proc_pkg::OP_NOT;
    import minisrc_proc_pkg::OP_HALT;
    import minisrc_proc_pkg::NUM_REGS;
    import minisrc_proc_pkg::ir_op;
    import minisrc_proc_pkg::ir_ra;
    import minisrc_proc_pkg::ir_rb;
    import minisrc_proc_pkg::ir_rc;

    state_t            state;
    logic [DATA_W-1:0] pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] z;
    logic [DATA_W-1:0] regs [NUM_REGS];

    // Decoded fields and operands of the current instruction
    logic [4:0]        op;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [3:0]        rc;
    logic [DATA_W-1:0] c_sext;
    logic [DATA_W-1:0] ra_val;
    logic [DATA_W-1:0] rb_val;
    logic [DATA_W-1:0] rc_val;
    logic [DATA_W-1:0] ea;

    // ALU interface
    alu_op_t           alu_op;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic              is_alu;

    assign op     = ir_op(ir);
    assign ra     = ir_ra(ir);
    assign rb     = ir_rb(ir);
    assign rc     = ir_rc(ir);
    assign c_sext = {{(DATA_W-19){ir[18]}}, ir[18:0]};
    assign ra_val = regs[ra];
    assign rb_val = regs[rb];
    assign rc_val = regs[rc];

    // Effective address: base register index 0 means "no base", not R0
    assign ea = ((rb == 4'd0) ? '0 : rb_val) + c_sext;

    assign dbg_state = state;

    // Map the opcode onto an ALU operation and its second operand
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = rc_val;
        is_alu = 1'b1;
        case (op)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_ADDI: begin
                alu_op = ALU_ADD;
                alu_b  = c_sext;
            end
            OP_NEG:  alu_op = ALU_NEG;
            OP_NOT:  alu_op = ALU_NOT;
            default: is_alu = 1'b0;
        endcase
    end

    minisrc_alu u_alu (
        .op (alu_op),
        .a  (rb_val),
        .b  (alu_b),
        .y  (alu_y)
    );

    // Control FSM, register file and registered memory request
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= ST_FETCH;
            pc        <= START_PC_ADDRESS[DATA_W-1:0];
            ir        <= '0;
            z         <= '0;
            oMemRead  <= 1'b0;
            oMemWrite <= 1'b0;
            oMemAddr  <= '0;
            oMemData  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!oMemRead) begin
                        // Only after reset: no request raised yet, raise it now
                        oMemRead <= 1'b1;
                        oMemAddr <= pc;
                    end else if (iMemRdy) begin
                        ir       <= iMemData;
                        pc       <= pc + 1'b1;
                        oMemRead <= 1'b0;
                        state    <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (op == OP_LD) begin
                        oMemRead <= 1'b1;
                        oMemAddr <= ea;
                        state    <= ST_MEM;
                    end else if (op == OP_ST) begin
                        oMemWrite <= 1'b1;
                        oMemAddr  <= ea;
                        oMemData  <= ra_val;
                        state     <= ST_MEM;
                    end else if (op == OP_HALT) begin
                        state <= ST_HALTED;
                    end else if (is_alu) begin
                        z     <= alu_y;
                        state <= ST_WB;
                    end else begin
                        // NOP and unknown opcodes: straight to the next fetch
                        oMemRead <= 1'b1;
                        oMemAddr <= pc;
                        state    <= ST_FETCH;
                    end
                end

                ST_MEM: begin
                    if (iMemRdy) begin
                        if (oMemWrite) begin
                            oMemWrite <= 1'b0;
                            oMemRead  <= 1'b1;
                            oMemAddr  <= pc;
                            state     <= ST_FETCH;
                        end else begin
                            z        <= iMemData;
                            oMemRead <= 1'b0;
                            state    <= ST_WB;
                        end
                    end
                end

                ST_WB: begin
                    regs[ra] <= z;
                    oMemRead <= 1'b1;
                    oMemAddr <= pc;
                    state    <= ST_FETCH;
                end

                ST_HALTED: begin
                    // Terminal: only reset leaves this state
                    oMemRead  <= 1'b0;
                    oMemWrite <= 1'b0;
                end

                default: begin
                    oMemRead  <= 1'b0;
                    oMemWrite <= 1'b0;
                    state     <= ST_HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minisrc_proc.sv
// Bench for minisrc_proc: memory responder with per-access stall plan,
// instruction-level reference interpreter, directed and random programs.
`timescale 1ns/1ps
module tb_minisrc_proc;
    import minisrc_proc_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_rdy = 1'b0;
    logic        mem_rd;
    logic        mem_wr;
    state_t      dbg_state;

    always #5 clk = ~clk;

    minisrc_proc dut (
        .iClk      (clk),
        .iRst      (rst),
        .oMemAddr  (mem_addr),
        .oMemData  (mem_wdata),
        .iMemData  (mem_rdata),
        .iMemRdy   (mem_rdy),
        .oMemRead  (mem_rd),
        .oMemWrite (mem_wr),
        .dbg_state (dbg_state)
    );

    // ISA constants, written out independently of the RTL package
    localparam logic [4:0] I_LD = 5'b00000, I_ST = 5'b00010, I_ADD = 5'b00011;
    localparam logic [4:0] I_SUB = 5'b00100, I_AND = 5'b00101, I_OR = 5'b00110;
    localparam logic [4:0] I_ADDI = 5'b01100, I_NEG = 5'b10001, I_NOT = 5'b10010;
    localparam logic [4:0] I_NOP = 5'b11010, I_HALT = 5'b11011;

    // ---------------- bench state ----------------
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem [256];
    int          stall_plan [256];
    int          acc_idx = 0;
    int          wait_cnt = 0;
    int          proto_err = 0;
    bit          seen_first = 0;
    logic [31:0] first_addr = 32'd0;
    bit          prev_pending = 0;
    logic        prev_rd = 0, prev_wr = 0;
    logic [31:0] prev_addr = 0, prev_data = 0;
    logic [31:0] act_addr_q [$];
    logic [31:0] act_q [$];
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_q [$];
    int          exp_cycles;
    logic [4:0]  op_tab [12] = '{I_LD, I_ST, I_ADD, I_SUB, I_AND, I_OR, I_ADDI,
                                 I_NEG, I_NOT, I_NOP, 5'b11111, 5'b00001};

    // ---------------- memory responder ----------------
    // Decide iMemRdy for the coming edge and watch request stability.
    always @(negedge clk) begin
        if (rst) begin
            mem_rdy      = 1'b0;
            wait_cnt     = 0;
            prev_pending = 0;
        end else begin
            if (mem_rd && mem_wr) proto_err++;
            if (prev_pending) begin
                if (mem_rd !== prev_rd || mem_wr !== prev_wr || mem_addr !== prev_addr ||
                    (mem_wr && mem_wdata !== prev_data)) proto_err++;
            end
            if (mem_rd || mem_wr) begin
                if (!seen_first) begin
                    first_addr = mem_addr;
                    seen_first = 1;
                end
                if (wait_cnt < stall_plan[acc_idx & 255]) begin
                    mem_rdy = 1'b0;
                    wait_cnt++;
                end else begin
                    mem_rdy   = 1'b1;
                    mem_rdata = mem_rd ? mem[mem_addr[7:0]] : $urandom;
                end
                prev_pending = !mem_rdy;
                prev_rd      = mem_rd;
                prev_wr      = mem_wr;
                prev_addr    = mem_addr;
                prev_data    = mem_wdata;
            end else begin
                mem_rdy      = 1'($urandom_range(0, 1));
                mem_rdata    = $urandom;
                prev_pending = 0;
            end
        end
    end

    // Access completion: commit writes, advance the stall plan
    always @(posedge clk) begin
        if (!rst && (mem_rd || mem_wr) && mem_rdy) begin
            if (mem_wr) begin
                mem[mem_addr[7:0]] = mem_wdata;
                act_addr_q.push_back(mem_addr);
                act_q.push_back(mem_wdata);
            end
            acc_idx++;
            wait_cnt = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [4:0] op, input int ra, input int rb, input int c);
        logic [31:0] w;
        logic [31:0] cv;
        cv = c;
        w = {op, 4'(ra), 4'(rb), cv[18:0]};
        return w;
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] op, input int ra, input int rb, input int rc);
        logic [31:0] w;
        w = {op, 4'(ra), 4'(rb), 4'(rc), 15'd0};
        return w;
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) begin
            mem[a] = 32'd0;
            stall_plan[a] = 0;
        end
    endtask

    // Instruction-level reference: architectural effect, store list and
    // total cycles from per-class latencies plus planned stall cycles.
    task automatic model_run();
        logic [31:0] mm [256];
        logic [31:0] r [16];
        logic [31:0] pc, ir, cs, ea;
        logic [4:0]  op;
        int          ra, rb, rc, acc, steps;
        bit          halted;
        mm = mem;
        for (int i = 0; i < 16; i++) r[i] = 32'd0;
        pc = 32'd0;
        exp_cycles = 1;
        acc = 0;
        steps = 0;
        halted = 0;
        exp_addr_q.delete();
        exp_q.delete();
        while (!halted && steps < 500) begin
            ir = mm[pc[7:0]];
            pc = pc + 1;
            exp_cycles += 1 + stall_plan[acc & 255];
            acc++;
            steps++;
            op = ir[31:27];
            ra = int'(ir[26:23]);
            rb = int'(ir[22:19]);
            rc = int'(ir[18:15]);
            cs = {{13{ir[18]}}, ir[18:0]};
            ea = ((rb == 0) ? 32'd0 : r[rb]) + cs;
            case (op)
                I_LD: begin
                    exp_cycles += 3 + stall_plan[acc & 255];
                    acc++;
                    r[ra] = mm[ea[7:0]];
                end
                I_ST: begin
                    exp_cycles += 2 + stall_plan[acc & 255];
                    acc++;
                    mm[ea[7:0]] = r[ra];
                    exp_addr_q.push_back(ea);
                    exp_q.push_back(r[ra]);
                end
                I_ADD:  begin exp_cycles += 2; r[ra] = r[rb] + r[rc]; end
                I_SUB:  begin exp_cycles += 2; r[ra] = r[rb] - r[rc]; end
                I_AND:  begin exp_cycles += 2; r[ra] = r[rb] & r[rc]; end
                I_OR:   begin exp_cycles += 2; r[ra] = r[rb] | r[rc]; end
                I_ADDI: begin exp_cycles += 2; r[ra] = r[rb] + cs; end
                I_NEG:  begin exp_cycles += 2; r[ra] = 32'd0 - r[rb]; end
                I_NOT:  begin exp_cycles += 2; r[ra] = ~r[rb]; end
                I_HALT: begin exp_cycles += 1; halted = 1; end
                default: exp_cycles += 1;
            endcase
        end
    endtask

    // Reset, run the loaded program to HALT, and check everything observable
    task automatic run_prog(input string name, output int cyc);
        bit done;
        int quiet;
        model_run();
        rst = 1'b1;
        acc_idx = 0;
        seen_first = 0;
        proto_err = 0;
        act_addr_q.delete();
        act_q.delete();
        repeat (2) @(negedge clk);
        check({name, "_rst_rd"}, 32'(mem_rd), 32'd0);
        check({name, "_rst_wr"}, 32'(mem_wr), 32'd0);
        check({name, "_rst_addr"}, mem_addr, 32'd0);
        check({name, "_rst_data"}, mem_wdata, 32'd0);
        rst = 1'b0;
        cyc = 0;
        done = 0;
        while (!done && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (dbg_state == ST_HALTED) done = 1;
        end
        check({name, "_halted"}, 32'(done), 32'd1);
        check({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
        check({name, "_nwrites"}, 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_waddr%0d", name, i), (i < act_addr_q.size()) ? act_addr_q[i] : 32'hxxxxxxxx, exp_addr_q[i]);
            check($sformatf("%s_wdata%0d", name, i), (i < act_q.size()) ? act_q[i] : 32'hxxxxxxxx, exp_q[i]);
        end
        check({name, "_first_fetch"}, first_addr, 32'd0);
        quiet = 0;
        repeat (50) begin
            @(negedge clk);
            if (mem_rd || mem_wr) quiet++;
        end
        check({name, "_halt_quiet"}, 32'(quiet), 32'd0);
        check({name, "_protocol"}, 32'(proto_err), 32'd0);
    endtask

    task automatic load_neg_prog();
        clear_mem();
        mem[0] = enc_i(I_LD, 3, 0, 20);
        mem[1] = enc_i(I_LD, 7, 0, 21);
        mem[2] = enc_i(I_LD, 2, 0, 22);
        mem[3] = enc_r(I_NEG, 4, 3, 0);
        mem[4] = {5'b11111, 27'h0123456};
        mem[5] = enc_i(I_ST, 4, 0, 23);
        mem[6] = enc_i(I_HALT, 0, 0, 0);
        mem[20] = 32'h22;
        mem[21] = 32'h24;
        mem[22] = 32'h28;
    endtask

    task automatic load_and_prog();
        clear_mem();
        mem[0] = enc_i(I_LD, 3, 0, 20);
        mem[1] = enc_i(I_LD, 7, 0, 21);
        mem[2] = enc_r(I_AND, 4, 3, 7);
        mem[3] = enc_i(I_ST, 4, 0, 23);
        mem[4] = enc_i(I_HALT, 0, 0, 0);
        mem[20] = 32'h22;
        mem[21] = 32'h24;
        mem[22] = 32'h28;
    endtask

    task automatic load_random_prog();
        logic [4:0] op;
        logic [31:0] rnd;
        for (int a = 0; a < 256; a++) begin
            mem[a] = $urandom;
            stall_plan[a] = $urandom_range(0, 2);
        end
        for (int i = 0; i < 20; i++) begin
            op = op_tab[$urandom_range(0, 11)];
            rnd = $urandom;
            if (op == I_LD || op == I_ST)
                mem[i] = enc_i(op, $urandom_range(0, 15), 0, $urandom_range(64, 255));
            else
                mem[i] = {op, rnd[26:0]};
        end
        mem[20] = enc_i(I_HALT, 0, 0, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int cyc0, cyc1, cyc;
        bit seen_wr;

        // NEG program: one store of -0x22 to word 23
        load_neg_prog();
        run_prog("neg", cyc);
        check("neg_spec_addr", (act_addr_q.size() > 0) ? act_addr_q[0] : 32'hxxxxxxxx, 32'd23);
        check("neg_spec_data", (act_q.size() > 0) ? act_q[0] : 32'hxxxxxxxx, 32'hFFFFFFDE);

        // AND program, no stalls then 3-cycle stalls on first fetch and first LD data
        load_and_prog();
        run_prog("and", cyc0);
        check("and_spec_data", (act_q.size() > 0) ? act_q[0] : 32'hxxxxxxxx, 32'h00000020);
        load_and_prog();
        stall_plan[0] = 3;
        stall_plan[1] = 3;
        run_prog("and_stall", cyc1);
        check("and_stall_data", (act_q.size() > 0) ? act_q[0] : 32'hxxxxxxxx, 32'h00000020);
        check("and_stall_delta", 32'(cyc1 - cyc0), 32'd6);

        // ADDI twice then store
        clear_mem();
        mem[0] = enc_i(I_ADDI, 1, 1, 10);
        mem[1] = enc_i(I_ADDI, 1, 1, 10);
        mem[2] = enc_i(I_ST, 1, 0, 5);
        mem[3] = enc_i(I_HALT, 0, 0, 0);
        run_prog("addi", cyc);
        check("addi_spec_addr", (act_addr_q.size() > 0) ? act_addr_q[0] : 32'hxxxxxxxx, 32'd5);
        check("addi_spec_data", (act_q.size() > 0) ? act_q[0] : 32'hxxxxxxxx, 32'd20);

        // Reset in the middle of a stalled store
        clear_mem();
        mem[0] = enc_i(I_ADDI, 1, 1, 7);
        mem[1] = enc_i(I_ST, 1, 0, 30);
        mem[2] = enc_i(I_HALT, 0, 0, 0);
        stall_plan[2] = 30;
        rst = 1'b1;
        acc_idx = 0;
        act_q.delete();
        act_addr_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_wr = 0;
        for (int i = 0; i < 100 && !seen_wr; i++) begin
            @(negedge clk);
            if (mem_wr) seen_wr = 1;
        end
        check("rstmid_store_seen", 32'(seen_wr), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_wr_drop", 32'(mem_wr), 32'd0);
        check("rstmid_rd_low", 32'(mem_rd), 32'd0);
        check("rstmid_addr_zero", mem_addr, 32'd0);
        check("rstmid_no_commit", 32'(act_q.size()), 32'd0);
        clear_mem();
        mem[0] = enc_i(I_ST, 1, 0, 31);
        mem[1] = enc_i(I_HALT, 0, 0, 0);
        run_prog("after_rst", cyc);
        check("after_rst_r1_zero", (act_q.size() > 0) ? act_q[0] : 32'hxxxxxxxx, 32'd0);

        // Random programs with random stalls
        for (int t = 0; t < 4; t++) begin
            load_random_prog();
            run_prog($sformatf("rand%0d", t), cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/minisrc_proc.md
Name: minisrc_proc

Overview:
- Multi-cycle, non-pipelined 32-bit MiniSRC processor core with a single shared instruction/data memory port.
- Fetches from PC, decodes, executes a load/store/ALU subset, and writes back to a 16-entry register file.
- Sits between the system clock/reset source and an external memory. The clock generator is a separate bench-side block and is not part of this spec.

Parameters:
- START_PC_ADDRESS, 0, word address loaded into PC on reset (shared constant START_PC_ADDRESS).
- DATA_W, 32, datapath and memory word width.

Ports:
- iClk  in  1  system clock; all state updates on the rising edge.
- iRst  in  1  asynchronous, active-high reset.
- oMemAddr  out  32  word address for fetch, load or store.
- oMemData  out  32  store data; valid while oMemWrite=1.
- iMemData  in  32  read data; sampled on the edge where oMemRead=1 and iMemRdy=1.
- iMemRdy  in  1  memory completes the current access when high.
- oMemRead  out  1  read request.
- oMemWrite  out  1  write request.

Behaviour:
- Reset (async, iRst=1):
  - PC=START_PC_ADDRESS, IR=0, all registers 0, state=FETCH.
  - oMemRead=0, oMemWrite=0, oMemAddr=0, oMemData=0.
  - A reset asserted mid-access aborts the access immediately.
- Instruction format: op[31:27], Ra[26:23], Rb[22:19], Rc[18:15], C[18:0]. C is sign-extended to 32 bits.
- Opcodes:
  - LD=00000, ST=00010, ADD=00011, SUB=00100, AND=00101, OR=00110.
  - ADDI=01100, NEG=10001, NOT=10010, NOP=11010, HALT=11011.
  - Any other opcode executes as NOP.
- Addressing: PC is a word address and increments by 1 per instruction.
- States:
  - FETCH: oMemRead=1, oMemAddr=PC. Hold until iMemRdy=1, then IR<=iMemData, PC<=PC+1, go to EXEC.
  - EXEC: compute result into a Z register, or compute the effective address.
    - Effective address EA = (Rb==0 ? 0 : R[Rb]) + sext(C).
    - LD/ST go to MEM. ALU ops go to WB. NOP goes to FETCH. HALT goes to HALTED.
  - MEM:
    - LD: oMemRead=1, oMemAddr=EA; on iMemRdy=1 latch data, go to WB.
    - ST: oMemWrite=1, oMemAddr=EA, oMemData=R[Ra]; on iMemRdy=1 go to FETCH.
  - WB: R[Ra]<=result, go to FETCH.
  - HALTED: terminal; only reset exits.
- ALU semantics (all 32-bit, wrap-around, no flags):
  - ADD: R[Rb]+R[Rc]. SUB: R[Rb]-R[Rc]. AND: R[Rb]&R[Rc]. OR: R[Rb]|R[Rc].
  - ADDI: R[Rb]+sext(C). NEG: 0-R[Rb]. NOT: ~R[Rb].
- R0 is a normal writable register. Its special case is only in EA computation (Rb=0 reads as 0).
- oMemRead and oMemWrite are never high together. Both are registered outputs, stable for the whole access.
- Latency with iMemRdy held at 1:
  - ALU ops: 3 cycles.
  - LD: 4 cycles.
  - ST: 3 cycles.
  - NOP: 2 cycles.
  - Each cycle of iMemRdy=0 adds one stall cycle.

Decomposition:
- Shared package/include: opcode constants (ISA), START_PC_ADDRESS, state encodings, instruction field-slice macros.
- One natural sub-module: minisrc_alu (combinational; op, A, B in; 32-bit result out).
- Register file and FSM live in the top module.

Test Plan:
- NEG program, iMemRdy=1. Memory word 20=0x22, 21=0x24, 22=0x28.
  - Program: LD r3,20(r0); LD r7,21(r0); LD r2,22(r0); NEG r4,r3; unknown op; ST r4,23(r0).
  - Required: single write, addr 23, data 0xFFFFFFDE.
- AND program: LD r3,20(r0); LD r7,21(r0); AND r4,r3,r7; ST r4,23(r0) -> write addr 23, data 0x00000020.
- ADDI r1,r1,10 twice then ST r1,5(r0) -> write addr 5, data 20. First fetch address equals START_PC_ADDRESS.
- iMemRdy held low 3 cycles during a fetch and during an LD -> oMemRead and oMemAddr stay stable. Result is unchanged; total cycle count increases by exactly 3 per stall.
- Assert iRst mid-MEM store -> oMemWrite drops immediately with no clock edge. After release, the next fetch is at START_PC_ADDRESS and registers read 0.
- HALT after ST -> no further oMemRead/oMemWrite for 50 cycles.
